// File: rtl/xeng_pkg.sv
// Shared types and sizing helpers for the X-engine accumulation controller.
package xeng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACC
  } xeng_state_e;

  localparam int WIN_CNT_W  = 32;
  localparam int DROP_CNT_W = 16;

  function automatic int win_len(input int s);
    return 1 << s;
  endfunction

  function automatic int tmr_w(input int n, input int l);
    return $clog2(n + l + 1);
  endfunction

endpackage

// File: rtl/xeng_dump_timer.sv
// Free-running dump timer: one start pulse yields a delayed burst of
// N_CMACS acc_valid cycles with acc_last on the final one.
module xeng_dump_timer
  import xeng_pkg::*;
#(
  parameter int N_CMACS         = 8,
  parameter int ACC_MUX_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_acc_valid,
  output logic o_acc_last,
  output logic o_active
);

  localparam int LAST = N_CMACS + ACC_MUX_LATENCY;
  localparam int TW   = tmr_w(N_CMACS, ACC_MUX_LATENCY);

  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;
  logic          r_active;
  logic          w_act_nxt;
  logic          r_valid;
  logic          r_last;

  // r_tmr holds the cycle offset from the scheduling en cycle
  always_comb begin
    w_tmr_nxt = '0;
    w_act_nxt = 1'b0;
    if (i_start) begin
      w_tmr_nxt = TW'(1);
      w_act_nxt = 1'b1;
    end else if (r_active && r_tmr != TW'(LAST)) begin
      w_tmr_nxt = r_tmr + 1'b1;
      w_act_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr    <= '0;
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_tmr    <= w_tmr_nxt;
      r_active <= w_act_nxt;
      r_valid  <= w_act_nxt &&
                  w_tmr_nxt >= TW'(ACC_MUX_LATENCY + 1);
      r_last   <= w_act_nxt && w_tmr_nxt == TW'(LAST);
    end
  end

  assign o_acc_valid = r_valid;
  assign o_acc_last  = r_last;
  assign o_active    = r_active;

endmodule

// File: rtl/xeng_acc_ctrl.sv
// X-engine accumulation controller: windowing FSM plus dump scheduling.
// Optional stats outputs enabled by defining XENG_ACC_CTRL_STATS_EN.
module xeng_acc_ctrl
  import xeng_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_CMACS             = 8,
  parameter int ACC_MUX_LATENCY     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  input  logic en,
  output logic cmac_sync,
  output logic acc_valid,
  output logic acc_last,
  output logic busy
`ifdef XENG_ACC_CTRL_STATS_EN
  ,
  output logic [WIN_CNT_W-1:0]  win_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int S   = SERIAL_ACC_LEN_BITS;
  localparam int WIN = win_len(S);
  localparam logic [S-1:0] CNT_ONE = S'(1);

  if (N_CMACS + ACC_MUX_LATENCY > WIN) begin : g_len_chk
    $fatal(1, "xeng_acc_ctrl: dump does not fit in one window");
  end

  xeng_state_e  r_state;
  logic [S-1:0] r_cnt;
  logic         r_sync;
  logic         w_start;
  logic         w_active;

  assign w_start = (r_state == ST_ACC) && en && (r_cnt == '1);

  // sync_in re-arms from any state; a window completing on the same
  // cycle still schedules its dump through w_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sync  <= 1'b0;
    end else begin
      r_sync <= 1'b0;
      if (sync_in) begin
        r_state <= ST_ARM;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_ARM: if (en) begin
            r_state <= ST_ACC;
            r_cnt   <= CNT_ONE;
            r_sync  <= 1'b1;
          end
          ST_ACC: if (en) begin
            r_cnt  <= r_cnt + 1'b1;
            r_sync <= (r_cnt == '0);
          end
          default: ;
        endcase
      end
    end
  end

  xeng_dump_timer #(
    .N_CMACS        (N_CMACS),
    .ACC_MUX_LATENCY(ACC_MUX_LATENCY)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .o_acc_valid(acc_valid),
    .o_acc_last (acc_last),
    .o_active   (w_active)
  );

  assign cmac_sync = r_sync;
  assign busy      = (r_state == ST_ACC) | w_active;

`ifdef XENG_ACC_CTRL_STATS_EN
  logic                  w_drop;
  logic [WIN_CNT_W-1:0]  r_win;
  logic [DROP_CNT_W-1:0] r_drop;

  assign w_drop = (r_state == ST_ACC) && sync_in &&
                  (r_cnt != '0) && !w_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win  <= '0;
      r_drop <= '0;
    end else begin
      if (acc_last && r_win != '1)
        r_win <= r_win + 1'b1;
      if (w_drop && r_drop != '1)
        r_drop <= r_drop + 1'b1;
    end
  end

  assign win_cnt  = r_win;
  assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_xeng_acc_ctrl.sv
// Scoreboard bench for xeng_acc_ctrl (S=3, N_CMACS=4, latency 2).
module tb_xeng_acc_ctrl;

  localparam int S    = 3;
  localparam int NC   = 4;
  localparam int LAT  = 2;
  localparam int NCYC = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_in = 1'b0;
  logic en = 1'b0;
  logic cmac_sync, acc_valid, acc_last, busy;
`ifdef XENG_ACC_CTRL_STATS_EN
  logic [31:0] win_cnt;
  logic [15:0] drop_cnt;
`endif

  xeng_acc_ctrl #(
    .SERIAL_ACC_LEN_BITS(S),
    .N_CMACS            (NC),
    .ACC_MUX_LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (sync_in),
    .en       (en),
    .cmac_sync(cmac_sync),
    .acc_valid(acc_valid),
    .acc_last (acc_last),
    .busy     (busy)
`ifdef XENG_ACC_CTRL_STATS_EN
    ,
    .win_cnt  (win_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int c;
    bit s;
    bit v;
    bit l;
  } ev_t;

  ev_t q[$];
  bit  xs[NCYC];
  bit  xv[NCYC];
  bit  xl[NCYC];
  bit  ssync[NCYC];
  bit  sen[NCYC];
  int  xbusy[NCYC];
  int  n_chk = 0;
  int  n_pass = 0;
  bit  mon_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // monitor: every cycle with a DUT output pulse consumes one expected event
  always @(negedge clk) begin
    ev_t e;
    if (mon_on && !rst && (cmac_sync || acc_valid || acc_last)) begin
      if (q.size() == 0) begin
        chk($sformatf("unexpected_c%0d", cyc),
            int'({cmac_sync, acc_valid, acc_last}), 0);
      end else begin
        e = q.pop_front();
        chk("event_cycle", cyc, e.c);
        chk($sformatf("event_flags_c%0d", cyc),
            int'({cmac_sync, acc_valid, acc_last}),
            int'({e.s, e.v, e.l}));
      end
    end
  end

  task automatic clear();
    for (int i = 0; i < NCYC; i++) begin
      xs[i] = 0; xv[i] = 0; xl[i] = 0;
      ssync[i] = 0; sen[i] = 0; xbusy[i] = -1;
    end
  endtask

  task automatic stim_en(input int a, input int b);
    for (int i = a; i <= b; i++) sen[i] = 1;
  endtask

  task automatic exp_dump(input int a, input int b);
    for (int i = a; i <= b; i++) xv[i] = 1;
    xl[b] = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmac_sync"}, int'(cmac_sync), 0);
    chk({tag, "_acc_valid"}, int'(acc_valid), 0);
    chk({tag, "_acc_last"},  int'(acc_last),  0);
    chk({tag, "_busy"},      int'(busy),      0);
  endtask

  task automatic run(input string name, input int rst_at,
                     input int ew, input int ed);
    rst = 1; sync_in = 0; en = 0; mon_on = 0;
    q.delete();
    repeat (2) @(negedge clk);
    for (int c = 0; c < NCYC; c++)
      if (xs[c] || xv[c] || xl[c])
        q.push_back('{c, xs[c], xv[c], xl[c]});
    rst = 0;
    mon_on = 1;
    chk_zero({name, "_rst"});
    for (int c = 0; c < NCYC; c++) begin
      if (xbusy[c] >= 0)
        chk($sformatf("%s_busy_c%0d", name, c), int'(busy), xbusy[c]);
      sync_in = ssync[c];
      en = sen[c];
      if (c == rst_at) begin
        #1 rst = 1;
        #1 chk_zero({name, "_midrst"});
        rst = 0;
      end
      @(negedge clk);
    end
    mon_on = 0;
    chk({name, "_missing_events"}, q.size(), 0);
`ifdef XENG_ACC_CTRL_STATS_EN
    chk({name, "_win_cnt"},  int'(win_cnt),  ew);
    chk({name, "_drop_cnt"}, int'(drop_cnt), ed);
`else
    if (ew < 0 || ed < 0) $display("bad stats args in %s", name);
`endif
  endtask

  initial begin
    // continuous en: windows at 4..11, 12..19, 20..
    clear();
    ssync[2] = 1; stim_en(4, 26);
    xs[5] = 1; xs[13] = 1; xs[21] = 1;
    exp_dump(14, 17); exp_dump(22, 25);
    xbusy[3] = 0; xbusy[5] = 1;
    run("basic", -1, 2, 0);

    // en gap at 6-7 shifts everything by two cycles
    clear();
    ssync[2] = 1; stim_en(4, 5); stim_en(8, 21);
    xs[5] = 1; xs[15] = 1;
    exp_dump(16, 19); exp_dump(24, 27);
    run("gap", -1, 2, 0);

    // sync mid-window drops the partial window
    clear();
    ssync[2] = 1; ssync[8] = 1; stim_en(4, 16);
    xs[5] = 1; xs[10] = 1;
    exp_dump(19, 22);
    xbusy[9] = 0;
    run("midsync", -1, 1, 1);

    // sync with en in ARM: sync wins
    clear();
    ssync[2] = 1; ssync[4] = 1; stim_en(4, 12);
    xs[6] = 1;
    exp_dump(15, 18);
    run("arm_sync", -1, 1, 0);

    // sync on the final sample still dumps; later sync leaves dump alone
    clear();
    ssync[2] = 1; ssync[11] = 1; ssync[15] = 1; stim_en(4, 11);
    xs[5] = 1;
    exp_dump(14, 17);
    xbusy[16] = 1; xbusy[19] = 0;
    run("end_sync", -1, 1, 0);

    // reset during the dump aborts it; controller idles until re-armed
    clear();
    ssync[2] = 1; ssync[20] = 1; stim_en(4, 24);
    xs[5] = 1; xs[13] = 1; xs[22] = 1;
    xv[14] = 1; xv[15] = 1;
    xbusy[18] = 0; xbusy[23] = 1;
    run("rst_dump", 15, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
